// File: rtl/paddle_input_conditioner.sv
// paddle_input_conditioner
//   Conditions one player's raw up/down push buttons into clean step commands.
//   Each button is synchronised, normalised to active-high, and debounced
//   independently. The debounced levels drive a small FSM that emits a
//   single-cycle step pulse on press, a second pulse after HOLD_DELAY cycles
//   of holding, then one pulse every REPEAT_PERIOD cycles while still held.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   vu_button     raw up button (asynchronous to clk)
//   vd_button     raw down button (asynchronous to clk)
//   step_up       registered one-cycle pulse: move one step up
//   step_down     registered one-cycle pulse: move one step down
//   held_up       debounced up level
//   held_down     debounced down level
//   dir_conflict  high while both debounced levels are high
module paddle_input_conditioner #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned HOLD_DELAY        = 15000000,
  parameter int unsigned REPEAT_PERIOD     = 200000,
  parameter int unsigned CNT_W             = 24,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vu_button,
  input  logic vd_button,
  output logic step_up,
  output logic step_down,
  output logic held_up,
  output logic held_down,
  output logic dir_conflict
);

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2
  } cmd_t;

  // Bit 0 = up, bit 1 = down.
  logic [1:0] raw_btn;
  logic [1:0] held;

  assign raw_btn = {vd_button, vu_button};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser and debouncer
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       deb_cnt_q;
    logic                   held_q;
    logic                   pressed;

    // Normalise so 1 always means pressed.
    assign pressed = sync_q[SYNC_STAGES-1] ^ BUTTON_ACTIVE_LOW;

    always_ff @(posedge clk) begin
      if (rst) begin
        // Reset to the released pin level so a button held through reset
        // has to traverse the full sync + debounce path again.
        sync_q    <= {SYNC_STAGES{BUTTON_ACTIVE_LOW}};
        deb_cnt_q <= '0;
        held_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_btn[b]};
        if (pressed == held_q) begin
          deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          held_q    <= ~held_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + CNT_W'(1);
        end
      end
    end

    assign held[b] = held_q;
  end

  assign held_up      = held[0];
  assign held_down    = held[1];
  assign dir_conflict = held[0] & held[1];

  // ---------------------------------------------------------------------------
  // Command decode: both held cancels motion.
  // ---------------------------------------------------------------------------
  cmd_t cmd;

  always_comb begin
    cmd = CMD_NONE;
    if (held[0] && !held[1]) begin
      cmd = CMD_UP;
    end else if (held[1] && !held[0]) begin
      cmd = CMD_DOWN;
    end
  end

  // ---------------------------------------------------------------------------
  // Step / hold-to-repeat FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  cmd_t             dir_q, dir_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             step_up_q, step_up_d;
  logic             step_down_q, step_down_d;
  logic [CNT_W-1:0] timer_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= CMD_NONE;
      timer_q     <= '0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
    end
  end

  assign timer_last = (state_q == DELAY) ? HOLD_LAST : REPEAT_LAST;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    timer_d     = timer_q;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (cmd != CMD_NONE) begin
          step_up_d   = (cmd == CMD_UP);
          step_down_d = (cmd == CMD_DOWN);
          dir_d       = cmd;
          state_d     = DELAY;
        end
      end

      DELAY, REPEAT: begin
        // Release beats an expiring timer; a reversal restarts the hold
        // sequence in the new direction immediately.
        if (cmd == CMD_NONE) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (cmd != dir_q) begin
          step_up_d   = (cmd == CMD_UP);
          step_down_d = (cmd == CMD_DOWN);
          dir_d       = cmd;
          timer_d     = '0;
          state_d     = DELAY;
        end else if (timer_q == timer_last) begin
          step_up_d   = (dir_q == CMD_UP);
          step_down_d = (dir_q == CMD_DOWN);
          timer_d     = '0;
          state_d     = REPEAT;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign step_up   = step_up_q;
  assign step_down = step_down_q;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// tb_paddle_input_conditioner
//   Self-checking bench for paddle_input_conditioner with small timing
//   parameters (sync 2, debounce 4, hold 10, repeat 3, active-high pins).
//   Cycle n is the interval that ends at clock edge n: inputs for cycle n are
//   sampled at edge n, and outputs observed in cycle n were registered at
//   edge n-1. Expected step pulses are queued per scenario and consumed as
//   the DUT emits them; debounced levels are checked every cycle.
module tb_paddle_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic vu_button;
  logic vd_button;
  logic step_up;
  logic step_down;
  logic held_up;
  logic held_down;
  logic dir_conflict;

  always #5 clk = ~clk;

  paddle_input_conditioner #(
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .HOLD_DELAY       (10),
    .REPEAT_PERIOD    (3),
    .CNT_W            (24),
    .BUTTON_ACTIVE_LOW(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vu_button   (vu_button),
    .vd_button   (vd_button),
    .step_up     (step_up),
    .step_down   (step_down),
    .held_up     (held_up),
    .held_down   (held_down),
    .dir_conflict(dir_conflict)
  );

  // Scoreboard entry: cycle at which a pulse must appear and its direction.
  typedef struct {
    int cyc;
    bit up;
  } pulse_t;

  // Table vector: raw up held for cycles [us,ue), raw down for [ds,de),
  // run ncyc cycles; pulses: +c = step_up at cycle c, -c = step_down.
  typedef struct {
    int us;
    int ue;
    int ds;
    int de;
    int ncyc;
    int np;
    int p[16];
  } vec_t;

  pulse_t sb[$];
  vec_t   vecs[5];
  int     errors = 0;
  int     checks = 0;

  task automatic set_vec(input int idx, input int us, input int ue, input int ds,
                         input int de, input int ncyc, input int pl[$]);
    vecs[idx].us   = us;
    vecs[idx].ue   = ue;
    vecs[idx].ds   = ds;
    vecs[idx].de   = de;
    vecs[idx].ncyc = ncyc;
    vecs[idx].np   = pl.size();
    for (int i = 0; i < 16; i++) begin
      vecs[idx].p[i] = (i < pl.size()) ? pl[i] : 0;
    end
  endtask

  task automatic push_pulse(input int p);
    pulse_t e;
    e.cyc = (p < 0) ? -p : p;
    e.up  = (p > 0);
    sb.push_back(e);
  endtask

  task automatic check1(input string name, input int n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  // Drive one cycle, observe mid-cycle, then advance past the edge.
  task automatic cycle_step(input string tag, input int n, input logic u, input logic d,
                            input logic r, input logic exp_hu, input logic exp_hd,
                            input bit chk);
    pulse_t e;
    vu_button = u;
    vd_button = d;
    rst       = r;
    @(negedge clk);
    if (chk) begin
      check1({tag, " held_up"}, n, held_up, exp_hu);
      check1({tag, " held_down"}, n, held_down, exp_hd);
      check1({tag, " dir_conflict"}, n, dir_conflict, exp_hu & exp_hd);
      if (step_up === 1'b1 && step_down === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL %s both_steps cycle %0d: got up=1 down=1 expected at most one", tag, n);
      end else if (step_up === 1'b1 || step_down === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_pulse cycle %0d: got up=%b down=%b expected none",
                   tag, n, step_up, step_down);
        end else begin
          e = sb.pop_front();
          if (e.cyc != n || e.up != step_up) begin
            errors++;
            $display("FAIL %s pulse cycle %0d: got up=%b at %0d expected up=%b at %0d",
                     tag, n, step_up, n, e.up, e.cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc == n) begin
        checks++;
        errors++;
        $display("FAIL %s missing_pulse cycle %0d: got none expected up=%b",
                 tag, n, sb[0].up);
        void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles; outputs must already be cleared in the second one.
  task automatic do_reset(input string tag);
    sb.delete();
    cycle_step(tag, -2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle_step(tag, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check1({tag, " reset step_up"}, -1, step_up, 1'b0);
    check1({tag, " reset step_down"}, -1, step_down, 1'b0);
  endtask

  task automatic end_scenario(input string tag);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s outstanding_pulses: got %0d left expected 0 (next at cycle %0d)",
               tag, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  // Stable presses of at least 4 cycles appear on the debounced level
  // exactly 6 cycles later (2 sync + 4 debounce) and last as long.
  function automatic logic win(input int s, input int e, input int n);
    return (s < e) && (n >= s + 6) && (n < e + 6);
  endfunction

  initial begin
    rst       = 1'b1;
    vu_button = 1'b0;
    vd_button = 1'b0;

    // clean press
    set_vec(0, 0, 6, 0, 0, 20, '{7});
    // shortest press that survives debounce
    set_vec(1, 0, 4, 0, 0, 20, '{7});
    // hold-to-repeat; last repeat lands while the debounced level is still high
    set_vec(2, 0, 40, 0, 0, 55, '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44});
    // conflict cancels motion, release of up resumes in the down direction
    set_vec(3, 0, 40, 21, 70, 85,
            '{7, 17, 20, 23, 26, -47, -57, -60, -63, -66, -69, -72, -75});
    // direction reversal in the same cycle
    set_vec(4, 0, 30, 30, 60, 75,
            '{7, 17, 20, 23, 26, 29, 32, 35, -37, -47, -50, -53, -56, -59, -62, -65});

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      do_reset(tag);
      for (int i = 0; i < vecs[v].np; i++) push_pulse(vecs[v].p[i]);
      for (int n = 0; n < vecs[v].ncyc; n++) begin
        cycle_step(tag, n,
                   (n >= vecs[v].us && n < vecs[v].ue),
                   (n >= vecs[v].ds && n < vecs[v].de),
                   1'b0,
                   win(vecs[v].us, vecs[v].ue, n),
                   win(vecs[v].ds, vecs[v].de, n),
                   1'b1);
      end
      end_scenario(tag);
    end

    // Bounce: 2-cycle toggling, then a 3-cycle glitch (longest rejected).
    do_reset("bounce");
    for (int n = 0; n < 40; n++) begin
      logic u;
      u = ((n < 20) && ((n / 2) % 2 == 0)) || (n >= 25 && n < 28);
      cycle_step("bounce", n, u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    end_scenario("bounce");

    // Reset in REPEAT with up still pressed: rst high in cycles 30 and 31,
    // so everything restarts from the first rst-low cycle 32.
    do_reset("rst_mid");
    foreach (vecs[2].p[i]) begin
      if (vecs[2].p[i] != 0 && vecs[2].p[i] <= 29) push_pulse(vecs[2].p[i]);
    end
    push_pulse(39);
    push_pulse(49);
    for (int n = 0; n < 51; n++) begin
      logic r;
      logic hu;
      r  = (n == 30 || n == 31);
      hu = (n >= 6) && !(n >= 31 && n <= 37);
      cycle_step("rst_mid", n, 1'b1, 1'b0, r, hu, 1'b0, 1'b1);
      if (n == 31) begin
        check1("rst_mid step_up_cleared", n, step_up, 1'b0);
        check1("rst_mid step_down_cleared", n, step_down, 1'b0);
      end
    end
    end_scenario("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
